pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Program-flow controller that computes and registers the 11-bit fetch address each cycle. It arbitrates between sequential increment, branch, call, return, and interrupt entry. It owns the hardware return-address stack and the interrupt-in-service state. Its pc output drives instruction fetch and replaces the standalone PC register in the fetch stage.

Parameters:
PC_WIDTH, 11, fetch address width
STACK_DEPTH, 8, return-address stack entries (power of 2)
RESET_VECTOR, 11'h000, first fetch address after reset
IRQ_VECTOR, 11'h004, interrupt service entry address

Ports:
clock  in  1  system clock; all state updates on falling edge
reset_bar  in  1  asynchronous active-low reset
stall  in  1  hold pc and all state this cycle
branch_taken  in  1  load branch_target
branch_target  in  PC_WIDTH  branch destination
call  in  1  push pc+1, load call_target
call_target  in  PC_WIDTH  call destination
ret  in  1  pop stack into pc
reti  in  1  pop stack into pc and leave ISR state
irq_req  in  1  level-sensitive interrupt request
irq_ack  out  1  one-cycle pulse on interrupt entry
in_isr  out  1  high while servicing an interrupt
pc  out  PC_WIDTH  current fetch address
stack_overflow  out  1  sticky: push attempted while full
stack_underflow  out  1  sticky: pop attempted while empty

Behaviour:
- Reset (async, reset_bar low): pc=RESET_VECTOR, state=HOLD, stack empty, in_isr=0, irq_ack=0, both error flags=0. This holds mid-operation too; any stack contents and ISR state are discarded.
- FSM states:
  - HOLD: pc stays at RESET_VECTOR for exactly one clock after reset release, and all inputs are ignored. Next state is RUN.
  - RUN: normal sequencing with interrupts enabled.
  - ISR: normal sequencing with irq_req masked.
- Next-pc priority per falling edge, highest first:
  1. stall: everything holds and irq_ack=0.
  2. ret or reti: pop into pc. reti also forces state to RUN; reti in RUN behaves as ret.
  3. call: push pc+1, pc=call_target.
  4. branch_taken: pc=branch_target.
  5. irq entry: only in RUN with irq_req=1. Push pc+1, pc=IRQ_VECTOR, state=ISR, irq_ack=1 for that cycle.
  6. default: pc=pc+1.
- Simultaneous events:
  - A lower-priority request in the same cycle is dropped; no queuing.
  - irq_req remains pending because it is level-sensitive, and is taken on the first eligible cycle.
- Arithmetic: pc+1 is modulo 2^PC_WIDTH, so 11'h7FF wraps to 11'h000 with no flag.
- Stack boundaries:
  - Push when full (count==STACK_DEPTH): push is dropped, stack_overflow set, and pc still loads the target.
  - Pop when empty: stack_underflow set and pc=pc+1.
  - Flags clear only on reset.
- Latency: requests sampled on a falling edge appear on pc after that same edge. in_isr equals (state==ISR).

Decomposition:
- Package pc_pkg holds: PC_WIDTH, RESET_VECTOR, IRQ_VECTOR, typedef pc_t (logic [PC_WIDTH-1:0]), and enum seq_state_t {HOLD, RUN, ISR}.
- Sub-module return_stack (push, pop, push_data, top, full, empty; LIFO with count register, depth parameterized). The sequencer instantiates one.

Test Plan:
1. Release reset -> pc=0x000 on the first edge (HOLD), then 0x001, 0x002, 0x003. Assert reset while pc=0x003 -> pc=0x000 immediately.
2. Call at pc=0x005, call_target=0x100 -> pc=0x100. Three increments later, ret -> pc=0x006, no flags set.
3. irq_req=1 at pc=0x010 in RUN -> irq_ack pulses once, pc=0x004, in_isr=1. Hold irq_req high -> no re-entry. reti -> pc=0x011, in_isr=0, irq re-enters on the next edge.
4. Nine consecutive calls with STACK_DEPTH=8 -> stack_overflow=1 on the ninth and pc=its target. Nine rets -> first eight return the correct addresses, the ninth sets stack_underflow with pc=pc+1.
5. Branch to 0x7FE, then run -> pc 0x7FF, 0x000. With stall=1 for 3 cycles and branch_taken=1 -> pc holds unchanged and the branch is not taken.
6. Same cycle: ret+call+branch_taken+irq_req -> ret wins. Next cycle: call+irq_req -> call wins, and irq is taken on the following idle cycle with the pushed address equal to call_target+1.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-flow sequencer.
// Revision: 1.0
`default_nettype none

package pc_pkg;

  localparam int PC_WIDTH    = 11;
  localparam int STACK_DEPTH = 8;

  typedef logic [PC_WIDTH-1:0] pc_t;

  localparam pc_t RESET_VECTOR = 11'h000;
  localparam pc_t IRQ_VECTOR   = 11'h004;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    ISR  = 2'd2
  } seq_state_t;

  // Sequential successor; wraps silently at the top of the address space.
  function automatic pc_t pc_incr(input pc_t pc);
    return pc + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the decode stage (master) and the sequencer (slave).
// Revision: 1.0
`default_nettype none

interface pc_sequencer_if;
  import pc_pkg::*;

  logic stall;
  logic branch_taken;
  pc_t  branch_target;
  logic call;
  pc_t  call_target;
  logic ret;
  logic reti;
  logic irq_req;
  logic irq_ack;
  logic in_isr;
  pc_t  pc;
  logic stack_overflow;
  logic stack_underflow;

  modport master (
    output stall, branch_taken, branch_target, call, call_target, ret, reti, irq_req,
    input  irq_ack, in_isr, pc, stack_overflow, stack_underflow
  );

  modport slave (
    input  stall, branch_taken, branch_target, call, call_target, ret, reti, irq_req,
    output irq_ack, in_isr, pc, stack_overflow, stack_underflow
  );

endinterface

`default_nettype wire

// File: rtl/return_stack.sv
// LIFO of return addresses with occupancy count; updates on the falling clock edge.
// Revision: 1.0
`default_nettype none

module return_stack #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  wire logic             clock,
  input  wire logic             reset_bar,
  input  wire logic             push,
  input  wire logic             pop,
  input  wire logic [WIDTH-1:0] push_data,
  output logic      [WIDTH-1:0] top,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_top_idx;

  assign w_wr_idx  = r_count[AW-1:0];
  assign w_top_idx = w_wr_idx - 1'b1;
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign top       = r_mem[w_top_idx];

  // Push takes precedence if a caller ever asserts both strobes.
  always_ff @(negedge clock or negedge reset_bar) begin
    if (!reset_bar) begin
      r_count <= '0;
    end else if (push && !full) begin
      r_count <= r_count + 1'b1;
    end else if (pop && !empty) begin
      r_count <= r_count - 1'b1;
    end
  end

  always_ff @(negedge clock) begin
    if (push && !full) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: increment, branch, call/return and interrupt entry, falling-edge state.
// Revision: 1.0
`default_nettype none

module pc_sequencer #(
  parameter int          STACK_DEPTH  = pc_pkg::STACK_DEPTH,
  parameter pc_pkg::pc_t RESET_VECTOR = pc_pkg::RESET_VECTOR,
  parameter pc_pkg::pc_t IRQ_VECTOR   = pc_pkg::IRQ_VECTOR
) (
  input  wire logic     clock,
  input  wire logic     reset_bar,
  pc_sequencer_if.slave bus
);
  import pc_pkg::*;

  seq_state_t r_state;
  pc_t        r_pc;
  logic       r_irq_ack;
  logic       r_in_isr;
  logic       r_overflow;
  logic       r_underflow;

  seq_state_t w_next_state;
  pc_t        w_next_pc;
  pc_t        w_pc_inc;
  logic       w_next_ack;
  logic       w_push;
  logic       w_pop;
  logic       w_set_ovf;
  logic       w_set_unf;
  pc_t        w_stack_top;
  logic       w_stack_full;
  logic       w_stack_empty;

  assign w_pc_inc = pc_incr(r_pc);

  return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock     (clock),
    .reset_bar (reset_bar),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_inc),
    .top       (w_stack_top),
    .full      (w_stack_full),
    .empty     (w_stack_empty)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_pc    = r_pc;
    w_next_ack   = 1'b0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_set_ovf    = 1'b0;
    w_set_unf    = 1'b0;

    if (r_state == HOLD) begin
      w_next_state = RUN;
    end else if (bus.stall) begin
      w_next_state = r_state;
    end else if (bus.ret || bus.reti) begin
      if (w_stack_empty) begin
        w_set_unf = 1'b1;
        w_next_pc = w_pc_inc;
      end else begin
        w_pop     = 1'b1;
        w_next_pc = w_stack_top;
      end
      if (bus.reti) begin
        w_next_state = RUN;
      end
    end else if (bus.call) begin
      w_push    = !w_stack_full;
      w_set_ovf = w_stack_full;
      w_next_pc = bus.call_target;
    end else if (bus.branch_taken) begin
      w_next_pc = bus.branch_target;
    end else if (r_state == RUN && bus.irq_req) begin
      // A full stack loses the return address but the vector is still entered.
      w_push       = !w_stack_full;
      w_set_ovf    = w_stack_full;
      w_next_pc    = IRQ_VECTOR;
      w_next_state = ISR;
      w_next_ack   = 1'b1;
    end else begin
      w_next_pc = w_pc_inc;
    end
  end

  always_ff @(negedge clock or negedge reset_bar) begin
    if (!reset_bar) begin
      r_state     <= HOLD;
      r_pc        <= RESET_VECTOR;
      r_irq_ack   <= 1'b0;
      r_in_isr    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_pc        <= w_next_pc;
      r_irq_ack   <= w_next_ack;
      r_in_isr    <= (w_next_state == ISR);
      r_overflow  <= r_overflow  | w_set_ovf;
      r_underflow <= r_underflow | w_set_unf;
    end
  end

  assign bus.pc              = r_pc;
  assign bus.irq_ack         = r_irq_ack;
  assign bus.in_isr          = r_in_isr;
  assign bus.stack_overflow  = r_overflow;
  assign bus.stack_underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; DUT state changes on the falling edge.
// Revision: 1.0
`default_nettype none

module tb_pc_sequencer;
  import pc_pkg::*;

  logic clock = 1'b1;
  logic reset_bar;
  int   tests  = 0;
  int   failed = 0;
  pc_t  exp_ret [9];

  always #5 clock = ~clock;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clock     (clock),
    .reset_bar (reset_bar),
    .bus       (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.branch_taken = 0; bus.branch_target = '0;
    bus.call = 0;  bus.call_target = '0; bus.ret = 0; bus.reti = 0; bus.irq_req = 0;
  endtask

  initial begin
    reset_bar = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clock);
    #1;
    check("rst_pc", bus.pc, 11'h000);
    check("rst_ack", bus.irq_ack, 0);
    check("rst_isr", bus.in_isr, 0);
    check("rst_ovf", bus.stack_overflow, 0);
    check("rst_unf", bus.stack_underflow, 0);

    // 1: HOLD ignores a branch, then sequential run, then async reset
    reset_bar = 1'b1;
    bus.branch_taken = 1; bus.branch_target = 11'h155;
    step(); check("hold_pc", bus.pc, 11'h000);
    bus.branch_taken = 0;
    step(); check("seq1", bus.pc, 11'h001);
    step(); check("seq2", bus.pc, 11'h002);
    step(); check("seq3", bus.pc, 11'h003);
    reset_bar = 1'b0;
    #1; check("async_rst_pc", bus.pc, 11'h000);
    #1; reset_bar = 1'b1;
    step(); check("hold2_pc", bus.pc, 11'h000);
    repeat (5) step();
    check("run_to_5", bus.pc, 11'h005);

    // 2: call / ret
    bus.call = 1; bus.call_target = 11'h100;
    step(); check("call_pc", bus.pc, 11'h100);
    bus.call = 0;
    repeat (3) step();
    check("callee_pc", bus.pc, 11'h103);
    bus.ret = 1;
    step(); check("ret_pc", bus.pc, 11'h006);
    bus.ret = 0;
    check("ret_ovf", bus.stack_overflow, 0);
    check("ret_unf", bus.stack_underflow, 0);

    // 3: interrupt entry, masking, reti and re-entry
    repeat (10) step();
    check("pre_irq_pc", bus.pc, 11'h010);
    bus.irq_req = 1;
    step();
    check("irq_pc", bus.pc, 11'h004);
    check("irq_ack", bus.irq_ack, 1);
    check("irq_isr", bus.in_isr, 1);
    step();
    check("masked_pc", bus.pc, 11'h005);
    check("masked_ack", bus.irq_ack, 0);
    check("masked_isr", bus.in_isr, 1);
    bus.reti = 1;
    step();
    check("reti_pc", bus.pc, 11'h011);
    check("reti_isr", bus.in_isr, 0);
    check("reti_ack", bus.irq_ack, 0);
    bus.reti = 0;
    step();
    check("reenter_pc", bus.pc, 11'h004);
    check("reenter_ack", bus.irq_ack, 1);
    check("reenter_isr", bus.in_isr, 1);
    bus.irq_req = 0; bus.reti = 1;
    step();
    check("reti2_pc", bus.pc, 11'h012);
    check("reti2_isr", bus.in_isr, 0);
    bus.reti = 0;

    // 4: nine calls overflow, nine rets underflow
    exp_ret[0] = 11'h013;
    for (int i = 1; i < 9; i++) exp_ret[i] = 11'h200 + 11'(i);
    bus.call = 1;
    for (int i = 0; i < 9; i++) begin
      bus.call_target = 11'h200 + 11'(i);
      step();
      check("deep_call_pc", bus.pc, 11'h200 + 11'(i));
      check("deep_call_ovf", bus.stack_overflow, (i == 8) ? 1 : 0);
    end
    bus.call = 0; bus.ret = 1;
    for (int i = 7; i >= 0; i--) begin
      step();
      check("deep_ret_pc", bus.pc, exp_ret[i]);
      check("deep_ret_unf", bus.stack_underflow, 0);
    end
    step();
    check("unf_pc", bus.pc, 11'h014);
    check("unf_flag", bus.stack_underflow, 1);
    bus.ret = 0;

    // 5: wrap and stall
    bus.branch_taken = 1; bus.branch_target = 11'h7FE;
    step(); check("br_pc", bus.pc, 11'h7FE);
    bus.branch_taken = 0;
    step(); check("wrap_7ff", bus.pc, 11'h7FF);
    step(); check("wrap_000", bus.pc, 11'h000);
    bus.stall = 1; bus.branch_taken = 1; bus.branch_target = 11'h123; bus.irq_req = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", bus.pc, 11'h000);
      check("stall_ack", bus.irq_ack, 0);
    end
    idle_inputs();

    // 6: priority among simultaneous requests
    bus.call = 1; bus.call_target = 11'h300;
    step(); check("pre_call_pc", bus.pc, 11'h300);
    bus.ret = 1; bus.call_target = 11'h350;
    bus.branch_taken = 1; bus.branch_target = 11'h360; bus.irq_req = 1;
    step();
    check("ret_wins_pc", bus.pc, 11'h001);
    check("ret_wins_ack", bus.irq_ack, 0);
    check("ret_wins_isr", bus.in_isr, 0);
    bus.ret = 0; bus.branch_taken = 0; bus.call_target = 11'h400;
    step();
    check("call_wins_pc", bus.pc, 11'h400);
    check("call_wins_ack", bus.irq_ack, 0);
    bus.call = 0;
    step();
    check("late_irq_pc", bus.pc, 11'h004);
    check("late_irq_ack", bus.irq_ack, 1);
    bus.irq_req = 0; bus.reti = 1;
    step();
    check("late_reti_pc", bus.pc, 11'h401);
    check("late_reti_isr", bus.in_isr, 0);
    bus.reti = 0; bus.ret = 1;
    step();
    check("late_ret_pc", bus.pc, 11'h002);
    bus.ret = 0;
    check("sticky_ovf", bus.stack_overflow, 1);
    check("sticky_unf", bus.stack_underflow, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
